alu_mdu: RTL

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/muldiv_iter.sv | 148 ++++++++++++++
 rtl/alu_mdu.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU / multiply-divide unit.
// Op encoding, default width and the iterative unit's state type.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_SLL   = 4'd3,
        OP_SRL   = 4'd4,
        OP_SRA   = 4'd5,
        OP_SUB   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_MULT  = 4'd8,
        OP_MULTU = 4'd9,
        OP_DIV   = 4'd10,
        OP_DIVU  = 4'd11,
        OP_NOR   = 4'd12,
        OP_MFHI  = 4'd13,
        OP_MFLO  = 4'd14,
        OP_RSVD  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    function automatic logic is_signed_op(alu_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(alu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiplier/divider, one bit per cycle on magnitudes.
// Divider datapath present only when ALU_MDU_DIV_EN is defined.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state;
    md_state_t        state_nx;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] md;
    logic             neg_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_MDU_DIV_EN
    logic             div_r;
    logic             neg_r;
    logic             dz_r;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic             unused_diff_msb;
`else
    logic             unused_is_div;
    assign unused_is_div = is_div;
`endif

    assign last  = (cnt == CW'(WIDTH - 1));
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nx;
    end

    // Next-state: IDLE -> BUSY for WIDTH steps -> DONE for one cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            MD_IDLE: if (start) state_nx = MD_BUSY;
            MD_BUSY: if (last)  state_nx = MD_DONE;
            MD_DONE:            state_nx = MD_IDLE;
            default:            state_nx = MD_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state != MD_IDLE);
        done = (state == MD_DONE);
    end

    // One step of shift-add multiply / restoring divide
    always_comb begin
        mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, md} : '0);
`ifdef ALU_MDU_DIV_EN
        rem_sh  = {hi_r, lo_r[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, md});
        diff    = rem_sh - {1'b0, md};
`endif
    end

`ifdef ALU_MDU_DIV_EN
    assign unused_diff_msb = diff[WIDTH];
`endif

    // Operand load on start, then iterate while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            md    <= '0;
            neg_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            div_r <= 1'b0;
            neg_r <= 1'b0;
            dz_r  <= 1'b0;
`endif
        end else if (state == MD_IDLE && start) begin
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= a_mag;
            md    <= b_mag;
            // b == 0 keeps the quotient all-ones regardless of sign
            neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
`ifdef ALU_MDU_DIV_EN
            div_r <= is_div;
            neg_r <= is_signed && a[WIDTH-1];
            dz_r  <= is_div && (b == '0);
`endif
        end else if (state == MD_BUSY) begin
            cnt <= cnt + CW'(1);
`ifdef ALU_MDU_DIV_EN
            if (div_r) begin
                hi_r <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], ge};
            end else begin
                hi_r <= mul_sum[WIDTH:1];
                lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
            end
`else
            hi_r <= mul_sum[WIDTH:1];
            lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
`endif
        end
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod   = neg_q ? -{hi_r, lo_r} : {hi_r, lo_r};
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        div_by_zero = 1'b0;
`ifdef ALU_MDU_DIV_EN
        if (div_r) begin
            res_lo      = neg_q ? -lo_r : lo_r;
            res_hi      = neg_r ? -hi_r : hi_r;
            div_by_zero = dz_r;
        end
`endif
    end

endmodule

// File: rtl/alu_mdu.sv
// ALU with HI/LO registers and an iterative multiply/divide unit.
// Define ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU return 0.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SW = $clog2(WIDTH);

    logic             accept;
    logic             iter_op;
    logic             md_start;
    logic             md_busy;
    logic             md_done;
    logic             md_dbz;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] alu_res;
    logic [SW-1:0]    shamt;

    assign shamt    = b[SW-1:0];
    assign in_ready = !md_busy;
    assign accept   = in_valid && in_ready;
    assign md_start = accept && iter_op;

    // Which ops go to the iterative unit
    always_comb begin
        iter_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
        iter_op = iter_op || is_div_op(op);
`endif
    end

    // Single-cycle result; iterative and reserved ops yield 0 here
    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SUB:  alu_res = a - b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NOR:  alu_res = ~(a | b);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .start      (md_start),
        .is_div     (is_div_op(op)),
        .is_signed  (is_signed_op(op)),
        .a          (a),
        .b          (b),
        .busy       (md_busy),
        .done       (md_done),
        .res_hi     (md_hi),
        .res_lo     (md_lo),
        .div_by_zero(md_dbz)
    );

    // Result, flags and HI/LO; the unit's DONE cycle and a new
    // accept never coincide since in_ready is low in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            out_valid   <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            if (md_done) begin
                out_valid   <= 1'b1;
                result      <= md_lo;
                zero        <= (md_lo == '0);
                div_by_zero <= md_dbz;
                hi          <= md_hi;
                lo          <= md_lo;
            end else if (accept && !iter_op) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
            end
        end
    end

endmodule
